// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] LIMIAR = 4'd5;

  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO   = 2'd0;
  localparam estado_t CONVERTE = 2'd1;
  localparam estado_t FIM      = 2'd2;

endpackage

// File: rtl/ajuste_bcd.sv
// One-digit corrector for shift-and-add-3: adds 3 when the digit is 5 or more.
module ajuste_bcd
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digito,
  output logic [DIGIT_W-1:0] ajustado
);

  assign ajustado = (digito >= LIMIAR) ? digito + 4'd3 : digito;

endmodule

// File: rtl/binario_para_bcd.sv
// Sequential binary-to-BCD converter, one input bit per cycle, registered result.
// Define BINARIO_PARA_BCD_SINAL_EN to treat the input as two's complement.
module binario_para_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        inicio,
  input  logic [WIDTH-1:0]            binario,
  output logic                        ocupado,
  output logic                        pronto,
  output logic [DIGITS*DIGIT_W-1:0]   bcd,
  output logic                        negativo,
  output estado_t                     estado
);

  // Handshake: a request is taken on any edge where inicio=1 and no conversion
  // is running; pronto is a single-cycle strobe meaning bcd/negativo just updated.

  localparam int CW = $clog2(WIDTH + 1);

  estado_t                     est;
  logic [CW-1:0]               contador;
  logic [WIDTH-1:0]            desloc, desloc_prox, magnitude;
  logic [DIGITS*DIGIT_W-1:0]   rascunho, ajustado, rasc_prox;
  logic                        aceita, termina;

  assign aceita  = inicio && ((est == OCIOSO) || (est == FIM));
  assign termina = (est == CONVERTE) && (contador == CW'(1));

  for (genvar k = 0; k < DIGITS; k++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .digito   (rascunho[k*DIGIT_W +: DIGIT_W]),
      .ajustado (ajustado[k*DIGIT_W +: DIGIT_W])
    );
  end

  assign {rasc_prox, desloc_prox} = {ajustado, desloc} << 1;

`ifdef BINARIO_PARA_BCD_SINAL_EN
  logic sinal;

  // Negating the most-negative value wraps to itself, which read as unsigned is 2^(WIDTH-1).
  assign magnitude = binario[WIDTH-1] ? (~binario) + WIDTH'(1) : binario;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sinal    <= 1'b0;
      negativo <= 1'b0;
    end else begin
      if (aceita)  sinal    <= binario[WIDTH-1];
      if (termina) negativo <= sinal;
    end
  end
`else
  assign magnitude = binario;
  assign negativo  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      est      <= OCIOSO;
      contador <= '0;
      desloc   <= '0;
      rascunho <= '0;
      bcd      <= '0;
    end else if (aceita) begin
      est      <= CONVERTE;
      desloc   <= magnitude;
      rascunho <= '0;
      contador <= CW'(WIDTH);
    end else if (est == CONVERTE) begin
      rascunho <= rasc_prox;
      desloc   <= desloc_prox;
      contador <= contador - CW'(1);
      if (termina) begin
        bcd <= rasc_prox;
        est <= FIM;
      end
    end else begin
      est <= OCIOSO;
    end
  end

  assign ocupado = (est == CONVERTE);
  assign pronto  = (est == FIM);
  assign estado  = est;

endmodule

// File: tb/tb_binario_para_bcd.sv
// Self-checking bench for binario_para_bcd: transaction-level model plus directed cases.
module tb_binario_para_bcd;
  import bcd_pkg::*;

  localparam int W = 16;
  localparam int D = 5;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           inicio = 1'b0;
  logic [W-1:0]   binario = '0;
  logic           ocupado, pronto, negativo;
  logic [4*D-1:0] bcd;
  estado_t        estado;

  int checks = 0;
  int failures = 0;

  binario_para_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .inicio   (inicio),
    .binario  (binario),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .bcd      (bcd),
    .negativo (negativo),
    .estado   (estado)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nome, act, exp);
    end
  endtask

  // reference model
  function automatic logic [4*D-1:0] to_bcd(input longint unsigned v);
    logic [4*D-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  logic [4*D-1:0] exp_q[$];
  logic           neg_q[$];
  int             ciclo = 0;
  int             e0 = -1000;
  logic [4*D-1:0] last_bcd = '0;
  logic           last_neg = 1'b0;

  always @(negedge reset_n) begin
    e0 = -1000;
    last_bcd = '0;
    last_neg = 1'b0;
    exp_q.delete();
    neg_q.delete();
  end

  always @(posedge clock) begin
    bit busy_before;
    longint unsigned v;
    logic sg;
    ciclo++;
    if (reset_n) begin
      busy_before = (ciclo - 1 >= e0) && (ciclo - 1 <= e0 + W - 1);
      if (ciclo == e0 + W && exp_q.size() > 0) begin
        last_bcd = exp_q.pop_front();
        last_neg = neg_q.pop_front();
      end
      if (!busy_before && inicio) begin
        v  = longint'(binario);
        sg = 1'b0;
`ifdef BINARIO_PARA_BCD_SINAL_EN
        if (binario[W-1]) begin
          sg = 1'b1;
          v  = (longint'(1) << W) - v;
        end
`endif
        exp_q.push_back(to_bcd(v));
        neg_q.push_back(sg);
        e0 = ciclo;
      end
    end
  end

  // compare process
  always @(negedge clock) begin
    if (reset_n && ciclo > 0) begin
      chk("ocupado", ocupado, (ciclo >= e0) && (ciclo <= e0 + W - 1));
      chk("pronto", pronto, ciclo == e0 + W);
      chk("bcd", bcd, last_bcd);
      chk("negativo", negativo, last_neg);
    end
  end

  // driver tasks
  task automatic espera_pronto(output int lat, output int occ);
    lat = 0;
    occ = 0;
    @(negedge clock);
    while (!pronto && lat < W + 5) begin
      if (ocupado) occ++;
      @(negedge clock);
      lat++;
    end
    if (!pronto) chk("timeout_pronto", 64'd0, 64'd1);
  endtask

  task automatic converte(input logic [W-1:0] v, input logic [4*D-1:0] lit, input logic neg);
    int lat, occ;
    @(posedge clock); #1;
    binario = v;
    inicio  = 1'b1;
    @(posedge clock); #1;
    inicio  = 1'b0;
    binario = W'($urandom);
    espera_pronto(lat, occ);
    chk("latencia", lat, W);
    chk("ocupado_ciclos", occ, W);
    chk("bcd_literal", bcd, lit);
    chk("negativo_literal", negativo, neg);
    @(negedge clock);
    chk("pronto_largura", pronto, 1'b0);
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    inicio  = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int lat, occ, t1, t2, n_pronto;
    reset_dut();
    @(negedge clock);
    chk("reset_ocupado", ocupado, 1'b0);
    chk("reset_pronto", pronto, 1'b0);
    chk("reset_bcd", bcd, 20'h0);
    chk("reset_negativo", negativo, 1'b0);
    chk("reset_estado", estado, OCIOSO);

    converte(16'd0, 20'h00000, 1'b0);
    converte(16'd1234, 20'h01234, 1'b0);

`ifdef BINARIO_PARA_BCD_SINAL_EN
    converte(16'hFFFF, 20'h00001, 1'b1);
    converte(16'h8000, 20'h32768, 1'b1);
    converte(16'h7FFF, 20'h32767, 1'b0);
`else
    // back-to-back with inicio held high
    @(posedge clock); #1;
    binario = 16'd65535;
    inicio  = 1'b1;
    @(posedge clock); #1;
    binario = 16'd9;
    espera_pronto(lat, occ);
    t1 = ciclo;
    chk("b2b_primeiro", bcd, 20'h65535);
    espera_pronto(lat, occ);
    t2 = ciclo;
    inicio = 1'b0;
    chk("b2b_intervalo", t2 - t1, W + 1);
    chk("b2b_segundo", bcd, 20'h00009);
`endif

    // inicio during a conversion is ignored
    repeat (3) @(posedge clock);
    #1 binario = 16'd42;
    inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    repeat (4) @(posedge clock);
    #1 binario = 16'd777;
    inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    espera_pronto(lat, occ);
    chk("ignorado_bcd", bcd, 20'h00042);
    n_pronto = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (pronto) n_pronto++;
    end
    chk("ignorado_um_pronto", n_pronto, 0);

    // reset mid-conversion
    @(posedge clock); #1;
    binario = 16'd4321;
    inicio  = 1'b1;
    @(posedge clock); #1;
    inicio  = 1'b0;
    repeat (7) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_ocupado", ocupado, 1'b0);
    chk("abort_pronto", pronto, 1'b0);
    chk("abort_bcd", bcd, 20'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    n_pronto = 0;
    repeat (2 * W) begin
      @(negedge clock);
      if (pronto) n_pronto++;
    end
    chk("abort_sem_pronto", n_pronto, 0);

    // randomized traffic
    repeat (1500) begin
      @(posedge clock); #1;
      inicio  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       binario = '0;
        1:       binario = '1;
        2:       binario = 16'h8000;
        default: binario = W'($urandom);
      endcase
    end
    @(posedge clock); #1 inicio = 1'b0;
    repeat (W + 4) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
